// File: rtl/riscv_pkg.sv
// Shared fetch-path types and constants for the instruction prefetch queue.
package riscv_pkg;

  localparam int          XLEN    = 32;
  localparam int          INST_W  = 32;
  localparam logic [31:0] PC_STEP = 32'd4;

  // One queued fetch result: the instruction word and the address it came from.
  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [XLEN-1:0]   pc;
  } fetch_entry_t;

  // Fetch addresses are always word aligned; low bits of a target are dropped.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return {pc[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/pf_fifo.sv
// Generic synchronous FIFO with flush. Pointers carry one extra MSB so that
// full (MSBs differ, index equal) and empty (pointers equal) are distinct.
// A write while full is accepted when a read happens in the same cycle.
module pf_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_wr, do_rd;

  // Status flags, qualified handshakes and next pointer values.
  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
               (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    count    = wr_ptr_q - rd_ptr_q;
    rd_data  = mem_q[rd_ptr_q[AW-1:0]];
    do_rd    = rd_en && !empty;
    do_wr    = wr_en && (!full || do_rd);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  // Pointer registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array; contents need no reset since the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (do_wr && !flush) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch queue: issues sequential word fetches, tags returning
// words with their PC, buffers them for decode and discards responses that
// belong to fetches made before a redirect or reset.
// Optional feature: define PREFETCH_BYPASS_EN to let a response reach decode
// in its arrival cycle when the queue is empty.
//
// Handshakes: a request transfers when imem_req_valid && imem_req_ready; a
// response is taken whenever imem_rsp_valid is high (no backpressure); an
// instruction is consumed when inst_valid && inst_ready.
module instr_prefetch_queue
  import riscv_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready
);

  localparam int            CW      = $clog2(DEPTH) + 1;
  localparam logic [CW+1:0] DEPTH_W = (CW+2)'(DEPTH);
  localparam logic [CW:0]   DEPTH_C = (CW+1)'(DEPTH);

  logic [XLEN-1:0] fpc_q, fpc_d;       // next fetch address
  logic [XLEN-1:0] rsp_pc_q, rsp_pc_d; // PC of the next live response
  logic [CW-1:0]   out_q, out_d;       // live requests still in flight
  logic [CW-1:0]   drop_q, drop_d;     // stale responses still to discard
  logic            hold_q;             // cycle after reset: stay quiet

  fetch_entry_t    fifo_wdata, fifo_rdata;
  logic            fifo_wr, fifo_rd, fifo_empty, fifo_full;
  logic [CW-1:0]   fifo_count;

  logic            req_fire, rsp_tracked, rsp_live, enq_ok, bypass, deq;
  logic [CW+1:0]   budget;
  logic [CW:0]     inflight_nxt;
  logic [CW-1:0]   drop_load;

  // Request gating, response classification and decode-side outputs.
  always_comb begin
    // Stale in-flight fetches are counted too, so total traffic never
    // exceeds the queue space even across back-to-back redirects.
    budget         = {2'b00, out_q} + {2'b00, drop_q} + {2'b00, fifo_count};
    imem_req_valid = !rst && !hold_q && !redirect && (budget < DEPTH_W);
    imem_req_addr  = fpc_q;
    req_fire       = imem_req_valid && imem_req_ready;
    rsp_live       = imem_rsp_valid && (drop_q == '0);
    enq_ok         = rsp_live && !redirect && !rst;
`ifdef PREFETCH_BYPASS_EN
    bypass         = fifo_empty && enq_ok;
`else
    bypass         = 1'b0;
`endif
    inst_valid     = !rst && !hold_q && (!fifo_empty || bypass);
    inst           = bypass ? imem_rsp_data : fifo_rdata.inst;
    inst_pc        = bypass ? rsp_pc_q      : fifo_rdata.pc;
    deq            = inst_valid && inst_ready && !redirect;
    fifo_rd        = deq && !fifo_empty;
    fifo_wr        = enq_ok && !(bypass && deq) && (!fifo_full || fifo_rd);
    fifo_wdata.inst = imem_rsp_data;
    fifo_wdata.pc   = rsp_pc_q;
  end

  // Next fetch PC, response PC tag and in-flight bookkeeping.
  always_comb begin
    // A response with nothing tracked in flight is ignored by the counters.
    rsp_tracked  = imem_rsp_valid && ((out_q != '0) || (drop_q != '0));
    inflight_nxt = {1'b0, out_q} + {1'b0, drop_q}
                 + {{CW{1'b0}}, req_fire} - {{CW{1'b0}}, rsp_tracked};
    // Legal traffic never exceeds DEPTH; a larger value only comes from
    // uninitialised state at power-up and is cleared instead of trusted.
    drop_load    = (inflight_nxt > DEPTH_C) ? '0 : inflight_nxt[CW-1:0];
    fpc_d        = fpc_q;
    rsp_pc_d     = rsp_pc_q;
    out_d        = out_q;
    drop_d       = drop_q;
    if (redirect) begin
      // Everything in flight becomes stale; the queue is flushed in the FIFO.
      fpc_d    = align_pc(redirect_pc);
      rsp_pc_d = align_pc(redirect_pc);
      out_d    = '0;
      drop_d   = drop_load;
    end else begin
      if (req_fire) fpc_d    = fpc_q + PC_STEP;
      if (enq_ok)   rsp_pc_d = rsp_pc_q + PC_STEP;
      if (imem_rsp_valid && (drop_q != '0)) drop_d = drop_q - 1'b1;
      out_d = out_q + {{(CW-1){1'b0}}, req_fire}
                    - {{(CW-1){1'b0}}, (rsp_live && (out_q != '0))};
    end
  end

  // State registers; reset discards in-flight fetches like a redirect.
  always_ff @(posedge clk) begin
    if (rst) begin
      fpc_q    <= RESET_PC;
      rsp_pc_q <= RESET_PC;
      out_q    <= '0;
      drop_q   <= drop_load;
      hold_q   <= 1'b1;
    end else begin
      fpc_q    <= fpc_d;
      rsp_pc_q <= rsp_pc_d;
      out_q    <= out_d;
      drop_q   <= drop_d;
      hold_q   <= 1'b0;
    end
  end

  pf_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush   (redirect),
    .wr_en   (fifo_wr),
    .wr_data (fifo_wdata),
    .rd_en   (fifo_rd),
    .rd_data (fifo_rdata),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .count   (fifo_count)
  );

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Self-checking bench for instr_prefetch_queue: an in-order memory model with
// random latency/ready, a decode-side scoreboard of the expected PC stream,
// directed phases followed by a randomized phase.
module tb_instr_prefetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  instr_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_ready     (inst_ready)
  );

  // ---------------- checking helpers ----------------
  int errors = 0;
  int checks = 0;

  task automatic check(input bit ok, input string name,
                       input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Program image: every address has a distinct word; 0x100 holds a known one.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h100) return 32'h0050_0113;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  // Scoreboard: the instruction stream decode should see, in order.
  logic [31:0] exp_q[$];

  task automatic set_stream(input logic [31:0] pc);
    logic [31:0] base;
    base = {pc[31:2], 2'b00};
    exp_q.delete();
    for (int k = 0; k < 1024; k++) exp_q.push_back(base + 32'(4 * k));
  endtask

  // ---------------- memory model ----------------
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] due;
  } mreq_t;

  mreq_t       infl_q[$];
  int          lat_min   = 1;
  int          lat_max   = 1;
  int          ready_pct = 100;
  int          req_count = 0;
  int          req_since = 0;
  int          cons_since = 0;
  logic [31:0] exp_fetch;
  logic [31:0] rsp_addr_cur;

  initial begin
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    rsp_addr_cur   = '0;
    exp_fetch      = RESET_PC;
    forever begin
      @(negedge clk);
      if (infl_q.size() > 0 && infl_q[0].due <= 32'(cyc)) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(infl_q[0].addr);
        rsp_addr_cur   = infl_q[0].addr;
      end else begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = $urandom;
      end
      imem_req_ready = ($urandom_range(0, 99) < ready_pct);
      #2;
      if (rst) begin
        exp_fetch = RESET_PC;
        req_since = 0;
      end else if (redirect) begin
        exp_fetch = {redirect_pc[31:2], 2'b00};
        req_since = 0;
      end
      if (imem_req_valid && imem_req_ready) begin
        check(imem_req_addr == exp_fetch, "req_addr", imem_req_addr, exp_fetch);
        exp_fetch = exp_fetch + 32'd4;
        req_count++;
        req_since++;
        check((req_since - cons_since) <= DEPTH, "no_overflow",
              32'(req_since - cons_since), 32'(DEPTH));
        infl_q.push_back({imem_req_addr,
                          32'(cyc) + 32'($urandom_range(lat_min, lat_max))});
      end
      if (imem_rsp_valid) void'(infl_q.pop_front());
    end
  end

  // ---------------- decode-side monitor ----------------
  int          stream_n   = 0;
  int          cons_total = 0;
  int unsigned cons_cyc[4];
  logic [31:0] first_pc   = '0;
  bit          rst_prev   = 1'b0;
  bit          probe_en   = 1'b0;
  bit          probe_done = 1'b0;

  initial begin
    logic [31:0] e;
    for (int i = 0; i < 4; i++) cons_cyc[i] = 0;
    forever begin
      @(negedge clk);
      #2;
      if (rst || rst_prev) begin
        check(!imem_req_valid, "reset_req_valid", 32'(imem_req_valid), 32'd0);
        check(!inst_valid, "reset_inst_valid", 32'(inst_valid), 32'd0);
      end
      if (redirect && !rst)
        check(!imem_req_valid, "redirect_req_valid", 32'(imem_req_valid), 32'd0);
      if (probe_en && !probe_done && imem_rsp_valid && rsp_addr_cur == 32'h100 &&
          !rst && !redirect) begin
        probe_done = 1'b1;
`ifdef PREFETCH_BYPASS_EN
        check(inst_valid, "bypass_valid", 32'(inst_valid), 32'd1);
        check(inst == 32'h0050_0113, "bypass_inst", inst, 32'h0050_0113);
`else
        check(!inst_valid, "no_bypass_latency", 32'(inst_valid), 32'd0);
`endif
      end
      if (rst || redirect) begin
        stream_n   = 0;
        cons_since = 0;
      end else if (inst_valid && inst_ready) begin
        if (exp_q.size() == 0) begin
          check(1'b0, "sb_underflow", inst_pc, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check(inst_pc == e, "inst_pc", inst_pc, e);
          check(inst == mem_word(e), "inst_data", inst, mem_word(e));
        end
        if (stream_n < 4) cons_cyc[stream_n] = cyc;
        if (stream_n == 0) first_pc = inst_pc;
        stream_n++;
        cons_since++;
        cons_total++;
      end
      rst_prev = rst;
    end
  end

  // ---------------- driver ----------------
  int ir_mode = 1; // 0: stall decode, 1: always ready, 2: random

  task automatic tick(input bit r, input bit rd, input logic [31:0] pc);
    @(negedge clk);
    rst         = r;
    redirect    = rd;
    redirect_pc = rd ? pc : $urandom;
    case (ir_mode)
      0:       inst_ready = 1'b0;
      1:       inst_ready = 1'b1;
      default: inst_ready = 1'($urandom_range(0, 1));
    endcase
    if (r) set_stream(RESET_PC);
    else if (rd) set_stream(pc);
  endtask

  task automatic do_reset();
    tick(1'b1, 1'b0, 32'd0);
    tick(1'b1, 1'b0, 32'd0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 32'd0);
  endtask

  task automatic wait_inflight(input int n);
    for (int i = 0; i < 30; i++) begin
      tick(1'b0, 1'b0, 32'd0);
      #3;
      if (infl_q.size() == n) break;
    end
    check(infl_q.size() == n, "wait_inflight", 32'(infl_q.size()), 32'(n));
  endtask

  initial begin
    int base;
    bit r, rd;
    rst = 1'b1; redirect = 1'b0; redirect_pc = '0; inst_ready = 1'b0;

    // Fill with 1-cycle memory and decode always ready: back-to-back PCs.
    ir_mode = 1; lat_min = 1; lat_max = 1; ready_pct = 100;
    do_reset();
    idle(12);
    #3;
    check(stream_n >= 4, "fill_count", 32'(stream_n), 32'd4);
    check(first_pc == RESET_PC, "fill_first_pc", first_pc, RESET_PC);
    check(cons_cyc[3] - cons_cyc[0] == 3, "fill_back_to_back",
          32'(cons_cyc[3] - cons_cyc[0]), 32'd3);

    // Decode stalled for 10 cycles: exactly DEPTH fetches, then no requests.
    ir_mode = 0;
    do_reset();
    base = req_count;
    idle(10);
    #3;
    check(req_count - base == DEPTH, "stall_req_count", 32'(req_count - base), 32'(DEPTH));
    check(!imem_req_valid, "stall_req_valid", 32'(imem_req_valid), 32'd0);
    check(stream_n == 0, "stall_no_consume", 32'(stream_n), 32'd0);
    ir_mode = 1;
    idle(20);
    #3;
    check(stream_n >= 8, "stall_release", 32'(stream_n), 32'd8);

    // Full queue released under random decode readiness: order preserved.
    ir_mode = 0;
    do_reset();
    idle(10);
    ir_mode = 2;
    idle(60);
    ir_mode = 1;
    idle(10);
    #3;
    check(stream_n > 20, "full_progress", 32'(stream_n), 32'd21);

    // Redirect with 3 fetches outstanding: those words must be dropped.
    lat_min = 6; lat_max = 6; ir_mode = 0;
    do_reset();
    wait_inflight(3);
    lat_min = 1; lat_max = 1; ir_mode = 1;
    tick(1'b0, 1'b1, 32'h40);
    idle(25);
    #3;
    check(first_pc == 32'h40, "redirect_first_pc", first_pc, 32'h40);
    check(stream_n > 4, "redirect_progress", 32'(stream_n), 32'd5);

    // Reset with 2 fetches outstanding from 0x200: stale words never surface.
    lat_min = 6; lat_max = 6; ir_mode = 1;
    do_reset();
    tick(1'b0, 1'b1, 32'h200);
    wait_inflight(2);
    lat_min = 1; lat_max = 1;
    do_reset();
    idle(30);
    #3;
    check(first_pc == RESET_PC, "reset_first_pc", first_pc, RESET_PC);
    check(stream_n > 4, "reset_progress", 32'(stream_n), 32'd5);

    // Response arriving at an empty queue (bypass or 1-cycle latency).
    lat_min = 3; lat_max = 3; ir_mode = 1;
    probe_en = 1'b1;
    tick(1'b0, 1'b1, 32'h100);
    idle(15);
    #3;
    check(probe_done, "probe_seen", 32'(probe_done), 32'd1);
    probe_en = 1'b0;

    // Randomized traffic: latency, memory ready, decode ready, redirects, resets.
    ir_mode = 2;
    for (int i = 0; i < 600; i++) begin
      if (i % 50 == 0) begin
        lat_min   = 1;
        lat_max   = $urandom_range(1, 4);
        ready_pct = $urandom_range(30, 100);
      end
      r  = ($urandom_range(0, 199) == 0);
      rd = !r && ($urandom_range(0, 99) < 3);
      tick(r, rd, $urandom & 32'h0000_3FFF);
    end
    ir_mode = 1; ready_pct = 100; lat_max = 1;
    idle(20);
    #3;
    check(cons_total > 200, "total_progress", 32'(cons_total), 32'd201);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Bound on total run time.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/instr_prefetch_queue.md
INSTR_PREFETCH_QUEUE -- requirements
Module: instr_prefetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, is the instruction queue entries; it SHALL be a power of 2 and at least 2.
REQ-002 Parameter RESET_PC, default 32'h0, is the first fetch address after reset.
REQ-003 clk  in  1  Single clock; all state SHALL update on the rising edge.
REQ-004 rst  in  1  Reset is synchronous and active-high.
REQ-005 imem_req_valid  out  1  Fetch request valid.
REQ-006 imem_req_addr  out  32  Fetch byte address, word-aligned.
REQ-007 imem_req_ready  in  1  Memory accepts the request.
REQ-008 imem_rsp_valid  in  1  Instruction word returned; responses arrive in order, at least 1 cycle after acceptance.
REQ-009 imem_rsp_data  in  32  Returned instruction word.
REQ-010 redirect  in  1  Branch taken or flush from execute.
REQ-011 redirect_pc  in  32  New fetch address.
REQ-012 inst_valid  out  1  Decode-side instruction valid.
REQ-013 inst  out  32  Instruction to decode.
REQ-014 inst_pc  out  32  PC of inst.
REQ-015 inst_ready  in  1  Decode consumes the instruction.

Function
REQ-016 A request SHALL transfer when imem_req_valid and imem_req_ready are both 1; a response SHALL be consumed when imem_rsp_valid is 1; an instruction SHALL be consumed when inst_valid and inst_ready are both 1.
REQ-017 Fetch PC register fpc SHALL advance by 4 on each accepted request.
REQ-018 imem_req_valid SHALL be 1 only when outstanding + occupancy < DEPTH, which prevents overflow.
REQ-019 Outstanding counter SHALL increment on request, decrement on response, and hold when both occur in the same cycle.
REQ-020 Each non-dropped response SHALL enqueue {data, pc}; the pc SHALL come from a parallel PC FIFO or a tag counter so that it matches issue order.
REQ-021 inst, inst_pc SHALL be the queue head; inst_valid SHALL equal !empty.
REQ-022 Simultaneous enqueue and dequeue SHALL leave occupancy unchanged, including when the queue is full.
REQ-023 On redirect: the queue SHALL be empty the next cycle; fpc SHALL become redirect_pc; drop_cnt SHALL become the outstanding count, minus 1 if a response arrives in the redirect cycle.
REQ-024 A request accepted in the redirect cycle SHALL also be counted in drop_cnt.
REQ-025 While drop_cnt > 0, each response SHALL be discarded and drop_cnt decremented; it SHALL NOT enqueue.
REQ-026 In the redirect cycle imem_req_valid SHALL be 0.
REQ-027 Redirect SHALL take priority over dequeue and enqueue in the same cycle; inst_ready in that cycle SHALL have no effect.
REQ-028 Pointers SHALL wrap modulo DEPTH; full and empty SHALL be distinguished by an extra pointer MSB.
REQ-029 redirect_pc[1:0] SHALL be ignored, treated as 0.

Reset
REQ-030 On rst: fpc = RESET_PC; queue empty; outstanding = 0; drop_cnt = 0; imem_req_valid = 0 and inst_valid = 0 in the reset cycle and the cycle after.
REQ-031 Reset during outstanding requests SHALL discard their later responses; drop_cnt SHALL be loaded exactly as for a redirect.

Configuration
REQ-032 With PREFETCH_BYPASS_EN defined: when the queue is empty and a non-dropped response arrives, it SHALL appear on inst/inst_valid in the same cycle.
REQ-033 With PREFETCH_BYPASS_EN defined: a bypassed response consumed that cycle SHALL NOT be enqueued.
REQ-034 Without PREFETCH_BYPASS_EN: minimum response-to-inst_valid latency SHALL be 1 cycle.

Structure
REQ-035 Package riscv_pkg SHALL hold XLEN = 32, INST_W = 32, PC_STEP = 4, and typedef fetch_entry_t {inst, pc}.
REQ-036 One sub-module, pf_fifo, SHALL implement a generic synchronous FIFO parameterised by width and DEPTH, with a flush input.

Verification
REQ-037 Bench SHALL cover: reset, memory always ready with 1-cycle latency, inst_ready = 1 -> inst_pc sequence 0, 4, 8, 12 on consecutive cycles after fill.
REQ-038 Bench SHALL cover: inst_ready = 0 for 10 cycles, DEPTH = 4 -> exactly 4 requests issued, then imem_req_valid = 0; no entry lost on release.
REQ-039 Bench SHALL cover: 3 outstanding requests with redirect to 0x40 -> those 3 responses dropped; next inst_pc = 0x40.
REQ-040 Bench SHALL cover: full queue with simultaneous dequeue and response -> occupancy stays 4; order preserved.
REQ-041 Bench SHALL cover: rst asserted with 2 outstanding -> inst_pc after reset = RESET_PC; stale words never reach inst.
REQ-042 Bench SHALL cover: with PREFETCH_BYPASS_EN, empty queue, response 0x00500113 at cycle N -> inst = 0x00500113 and inst_valid = 1 at cycle N.
